// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: XLEN, reset vector,
// FSM encodings, NOP word and queue entry layout (entry grows under FETCH_EXC_CHECK_EN).
package inst_prefetch_queue_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      DISCARD = 2'b01,
      HOLD    = 2'b10
   } fetch_state_e;

   typedef struct packed {
`ifdef FETCH_EXC_CHECK_EN
      logic            exc;
`endif
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } queue_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
// Circular buffer holding fetched entries; pointers wrap modulo DEPTH,
// flush empties the queue in one edge.
module inst_prefetch_queue_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: request FSM (FETCH/DISCARD/HOLD) plus fetch_fifo.
// Define FETCH_EXC_CHECK_EN to add the per-entry fetch exception flag and inst_exc port.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int              DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_EXC_CHECK_EN
   output logic            inst_exc,
`endif
   output logic [XLEN-1:0] inst_pc4
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   fetch_state_e    state_q, state_next;
   logic            req_q, req_next;
   logic [XLEN-1:0] req_addr_q, addr_next;
   logic [XLEN-1:0] fetch_pc_q, pc_next;
   logic [CNT_W-1:0] count, count_next;
   logic            ack_done, push, pop, pending_after, head_valid;
   logic            unused_pc_bit0;
   queue_entry_t    push_entry, head_entry;

   assign unused_pc_bit0 = redirect_pc[0];

   assign ack_done      = req_q & imem_ack;
   assign pending_after = req_q & ~imem_ack;
   assign push          = ack_done & (state_q != DISCARD) & ~redirect;
   assign pop           = head_valid & ~stall & ~redirect;

   always_comb begin
      push_entry      = '0;
      push_entry.inst = imem_rdata;
      push_entry.pc   = req_addr_q;
`ifdef FETCH_EXC_CHECK_EN
      push_entry.exc  = (imem_rdata[1:0] != 2'b11) | fetch_pc_q[1];
`endif
   end

   inst_prefetch_queue_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(queue_entry_t))
   ) fetch_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head_entry),
      .count      (count)
   );

   always_comb begin
      count_next = count;
      if (redirect) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
   end

   // An outstanding request keeps req/addr frozen; otherwise a new one is
   // issued whenever the queue will still have a free slot after this edge.
   always_comb begin
      state_next = state_q;
      req_next   = 1'b0;
      addr_next  = req_addr_q;
      pc_next    = fetch_pc_q;

      if (redirect) begin
         pc_next = {redirect_pc[XLEN-1:1], 1'b0};
      end else if (ack_done && state_q != DISCARD) begin
         pc_next = fetch_pc_q + 32'd4;
      end

      if (pending_after) begin
         req_next   = 1'b1;
         state_next = (redirect || state_q == DISCARD) ? DISCARD : FETCH;
      end else if (count_next < DEPTH_CNT) begin
         req_next   = 1'b1;
         addr_next  = pc_next;
         state_next = FETCH;
      end else begin
         state_next = HOLD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         req_q      <= 1'b0;
         req_addr_q <= '0;
         fetch_pc_q <= RESET_VECTOR;
      end else begin
         state_q    <= state_next;
         req_q      <= req_next;
         req_addr_q <= addr_next;
         fetch_pc_q <= pc_next;
      end
   end

   // Head fields are forced to zero when empty so outputs are clean in reset.
   assign imem_req   = req_q;
   assign imem_addr  = req_addr_q;
   assign inst_valid = head_valid;
   assign inst       = head_valid ? head_entry.inst : '0;
   assign inst_pc    = head_valid ? head_entry.pc : '0;
   assign inst_pc4   = head_valid ? (head_entry.pc + 32'd4) : '0;
`ifdef FETCH_EXC_CHECK_EN
   assign inst_exc   = head_valid & head_entry.exc;
`endif

endmodule
